// File: rtl/swd_target_responder_if.sv
// SWD target-side signal bundle: wire pins, ACK programming and transaction status.
// The target uses the slave modport; the host or bench side uses master.
interface swd_target_responder_if;
    logic        swclk;
    logic        swdio_in;
    logic        swdio_out;
    logic        swdio_oe;
    logic [2:0]  ack_cfg;
    logic        req_valid;
    logic        req_apndp;
    logic        req_rnw;
    logic [1:0]  req_addr;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        parity_err;
    logic        line_reset;

    modport slave (
        input  swclk, swdio_in, ack_cfg,
        output swdio_out, swdio_oe, req_valid, req_apndp, req_rnw, req_addr,
               wr_valid, wr_data, parity_err, line_reset
    );

    modport master (
        output swclk, swdio_in, ack_cfg,
        input  swdio_out, swdio_oe, req_valid, req_apndp, req_rnw, req_addr,
               wr_valid, wr_data, parity_err, line_reset
    );
endinterface

// File: rtl/swd_target_responder.sv
// SWD target: oversamples swclk/swdio on sck, decodes requests, returns a programmable
// ACK and serves reads/writes from an 8x32 DP/AP bank.
module swd_target_responder #(
    parameter logic [31:0] IDCODE       = 32'h0BA00477,
    parameter int          LINE_RST_LEN = 50
) (
    input  logic                         sck,
    input  logic                         rst_n,
    swd_target_responder_if.slave        bus
);
    localparam int             LRW     = $clog2(LINE_RST_LEN + 1);
    localparam logic [LRW-1:0] LR_LAST = LRW'(LINE_RST_LEN - 1);
    localparam logic [LRW-1:0] LR_MAX  = LRW'(LINE_RST_LEN);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_TRN1  = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;
    localparam logic [2:0] ST_TRN3  = 3'd5;
    localparam logic [2:0] ST_TRN2  = 3'd6;
    localparam logic [2:0] ST_WDATA = 3'd7;

    function automatic logic even_par(input logic [31:0] d);
        return ^d;
    endfunction

    function automatic logic req_ok(input logic [7:0] r);
        return (r[5] == (r[1] ^ r[2] ^ r[3] ^ r[4])) && r[0] && !r[6] && r[7];
    endfunction

    logic [2:0]     clk_sync_q;
    logic [1:0]     dio_sync_q;
    logic [2:0]     state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [6:0]     req_sh_q, req_sh_d;
    logic           apndp_q, apndp_d, rnw_q, rnw_d;
    logic [1:0]     addr_q, addr_d;
    logic [2:0]     ack_q, ack_d;
    logic [31:0]    rdata_q, rdata_d, wsh_q, wsh_d, wr_data_q, wr_data_d;
    logic [LRW-1:0] lr_cnt_q, lr_cnt_d;
    logic           out_q, out_d, oe_q, oe_d;
    logic           req_valid_q, req_valid_d, wr_valid_q, wr_valid_d;
    logic           perr_q, perr_d, lr_pulse_q, lr_pulse_d;
    logic           bank_we_s;
    logic [2:0]     bank_wa_s;
    logic [31:0]    bank_q [8];

    logic        rise_s, fall_s, dio_s, lr_hit_s, dp0_s;
    logic [31:0] rd_word_s;

    assign rise_s    = clk_sync_q[1] & ~clk_sync_q[2];
    assign fall_s    = ~clk_sync_q[1] & clk_sync_q[2];
    assign dio_s     = dio_sync_q[1];
    assign lr_hit_s  = rise_s && dio_s && (lr_cnt_q == LR_LAST);
    assign dp0_s     = !apndp_q && (addr_q == 2'b00);
    assign rd_word_s = dp0_s ? IDCODE : bank_q[{apndp_q, addr_q}];

    // Two-flop synchronizers plus a history flop on swclk for edge detection.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 3'b000;
            dio_sync_q <= 2'b00;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], bus.swclk};
            dio_sync_q <= {dio_sync_q[0], bus.swdio_in};
        end
    end

    // Next-state logic: protocol FSM, line-reset counter and output drive values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_sh_d    = req_sh_q;
        apndp_d     = apndp_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        wsh_d       = wsh_q;
        wr_data_d   = wr_data_q;
        out_d       = out_q;
        oe_d        = oe_q;
        perr_d      = perr_q;
        req_valid_d = 1'b0;
        wr_valid_d  = 1'b0;
        lr_pulse_d  = 1'b0;
        bank_we_s   = 1'b0;
        bank_wa_s   = {apndp_q, addr_q};

        if (rise_s && dio_s) begin
            lr_cnt_d = (lr_cnt_q != LR_MAX) ? lr_cnt_q + LRW'(1) : lr_cnt_q;
        end else if (rise_s) begin
            lr_cnt_d = '0;
        end else begin
            lr_cnt_d = lr_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise_s && dio_s) begin
                    state_d  = ST_REQ;
                    cnt_d    = 6'd1;
                    req_sh_d = 7'h01;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rise_s && cnt_q == 6'd7) begin
                    if (req_ok({dio_s, req_sh_q})) begin
                        req_valid_d = 1'b1;
                        apndp_d     = req_sh_q[1];
                        rnw_d       = req_sh_q[2];
                        addr_d      = {req_sh_q[4], req_sh_q[3]};
                        cnt_d       = 6'd0;
                        state_d     = ST_TRN1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (rise_s) begin
                    req_sh_d[cnt_q[2:0]] = dio_s;
                    cnt_d                = cnt_q + 6'd1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            // The fall right after the request still belongs to the host; drive on the next one.
            ST_TRN1: begin
                if (rise_s) begin
                    cnt_d = 6'd1;
                end else if (fall_s && cnt_q == 6'd1) begin
                    ack_d   = bus.ack_cfg;
                    out_d   = bus.ack_cfg[0];
                    oe_d    = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_TRN1;
                end
            end
            ST_ACK: begin
                if (fall_s && cnt_q < 6'd3) begin
                    out_d = ack_q[cnt_q[1:0]];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd2) begin
                        rdata_d = rd_word_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (fall_s && (ack_q != 3'b001 || !rnw_q)) begin
                    oe_d    = 1'b0;
                    out_d   = 1'b0;
                    state_d = (ack_q != 3'b001) ? ST_IDLE : ST_TRN2;
                end else if (fall_s) begin
                    out_d   = rdata_q[0];
                    cnt_d   = 6'd1;
                    state_d = ST_RDATA;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_RDATA: begin
                if (fall_s && cnt_q < 6'd32) begin
                    out_d = rdata_q[cnt_q[4:0]];
                    cnt_d = cnt_q + 6'd1;
                end else if (fall_s && cnt_q == 6'd32) begin
                    out_d = even_par(rdata_q);
                    cnt_d = cnt_q + 6'd1;
                end else if (fall_s) begin
                    oe_d    = 1'b0;
                    out_d   = 1'b0;
                    state_d = ST_TRN3;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_TRN3: begin
                state_d = rise_s ? ST_IDLE : ST_TRN3;
            end
            ST_TRN2: begin
                if (rise_s) begin
                    cnt_d   = 6'd0;
                    state_d = ST_WDATA;
                end else begin
                    state_d = ST_TRN2;
                end
            end
            ST_WDATA: begin
                if (rise_s && cnt_q < 6'd32) begin
                    wsh_d[cnt_q[4:0]] = dio_s;
                    cnt_d             = cnt_q + 6'd1;
                end else if (rise_s && dio_s == even_par(wsh_q)) begin
                    bank_we_s  = !dp0_s;
                    wr_data_d  = wsh_q;
                    wr_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (rise_s) begin
                    perr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line reset overrides whatever the FSM decided this cycle.
        if (lr_hit_s) begin
            state_d     = ST_IDLE;
            oe_d        = 1'b0;
            out_d       = 1'b0;
            perr_d      = 1'b0;
            lr_pulse_d  = 1'b1;
            req_valid_d = 1'b0;
            wr_valid_d  = 1'b0;
            wr_data_d   = wr_data_q;
            bank_we_s   = 1'b0;
        end else begin
            lr_pulse_d = 1'b0;
        end
    end

    // FSM, shift registers and registered outputs.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            req_sh_q    <= 7'd0;
            apndp_q     <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= 2'b00;
            ack_q       <= 3'b000;
            rdata_q     <= 32'd0;
            wsh_q       <= 32'd0;
            wr_data_q   <= 32'd0;
            lr_cnt_q    <= '0;
            out_q       <= 1'b0;
            oe_q        <= 1'b0;
            req_valid_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            perr_q      <= 1'b0;
            lr_pulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_sh_q    <= req_sh_d;
            apndp_q     <= apndp_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            wsh_q       <= wsh_d;
            wr_data_q   <= wr_data_d;
            lr_cnt_q    <= lr_cnt_d;
            out_q       <= out_d;
            oe_q        <= oe_d;
            req_valid_q <= req_valid_d;
            wr_valid_q  <= wr_valid_d;
            perr_q      <= perr_d;
            lr_pulse_q  <= lr_pulse_d;
        end
    end

    // DP/AP register bank.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= 32'd0;
            end
        end else if (bank_we_s) begin
            bank_q[bank_wa_s] <= wsh_q;
        end
    end

    assign bus.swdio_out  = out_q;
    assign bus.swdio_oe   = oe_q;
    assign bus.req_valid  = req_valid_q;
    assign bus.req_apndp  = apndp_q;
    assign bus.req_rnw    = rnw_q;
    assign bus.req_addr   = addr_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.parity_err = perr_q;
    assign bus.line_reset = lr_pulse_q;
endmodule

// File: tb/tb_swd_target_responder.sv
// Scoreboard bench for swd_target_responder: the host model pushes expected wire bits and
// transaction events into queues; independent monitors pop and compare them.
module tb_swd_target_responder;
    localparam logic [31:0] IDCODE = 32'h0BA00477;

    logic sck = 1'b0;
    logic rst_n = 1'b0;
    logic host_drv = 1'b0;
    logic mon_en = 1'b0;
    logic exp_perr = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [1:0]  wire_q [$];
    logic [31:0] wr_q   [$];
    logic [3:0]  req_q  [$];
    int          lr_q   [$];
    logic [31:0] model  [8];

    swd_target_responder_if bus();

    swd_target_responder dut (
        .sck   (sck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 sck = ~sck;

    assign bus.swdio_in = bus.swdio_oe ? bus.swdio_out : host_drv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Wire monitor: the host samples the pad on every swclk rise.
    always @(posedge bus.swclk) begin : wire_mon
        logic [1:0] e;
        if (mon_en) begin
            if (wire_q.size() == 0) begin
                unexpected("wire_extra_cycle");
            end else begin
                e = wire_q.pop_front();
                check("wire_oe_out", 32'({bus.swdio_oe, bus.swdio_out}), 32'(e));
            end
        end
    end

    // Event monitor for the one-cycle status pulses.
    always @(negedge sck) begin : evt_mon
        logic [31:0] w;
        logic [3:0]  r;
        int          l;
        if (mon_en && bus.req_valid) begin
            if (req_q.size() == 0) unexpected("req_valid");
            else begin
                r = req_q.pop_front();
                check("req_fields", 32'({bus.req_addr, bus.req_rnw, bus.req_apndp}), 32'(r));
            end
        end
        if (mon_en && bus.wr_valid) begin
            if (wr_q.size() == 0) unexpected("wr_valid");
            else begin
                w = wr_q.pop_front();
                check("wr_data", bus.wr_data, w);
            end
        end
        if (mon_en && bus.line_reset) begin
            if (lr_q.size() == 0) unexpected("line_reset");
            else l = lr_q.pop_front();
        end
    end

    task automatic hcycle(input logic drv, input logic oe_e, input logic out_e);
        wire_q.push_back({oe_e, out_e});
        @(negedge sck);
        bus.swclk = 1'b0;
        host_drv  = drv;
        repeat (6) @(negedge sck);
        bus.swclk = 1'b1;
        repeat (5) @(negedge sck);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) hcycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [7:0] req, input logic [2:0] ack, input logic [31:0] wd,
                         input logic bad_par, input int abort_bit);
        logic        ok;
        logic [2:0]  idx;
        logic [31:0] word;
        bus.ack_cfg = ack;
        ok  = (req[5] == ^req[4:1]) && req[0] && !req[6] && req[7];
        idx = {req[1], req[4], req[3]};
        word = (idx == 3'd0) ? IDCODE : model[idx];
        if (ok) req_q.push_back(req[4:1]);
        for (int i = 0; i < 8; i++) hcycle(req[i], 1'b0, 1'b0);
        if (!ok) begin
            idle(40);
            return;
        end
        hcycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) hcycle(1'b0, 1'b1, ack[i]);
        if (ack != 3'b001) begin
            hcycle(1'b0, 1'b0, 1'b0);
        end else if (req[2]) begin
            for (int i = 0; i < 32; i++) begin
                hcycle(1'b0, 1'b1, word[i]);
                if (i == abort_bit) begin
                    rst_n = 1'b0;
                    #1;
                    check("oe_after_async_rst", 32'(bus.swdio_oe), 32'd0);
                    check("out_after_async_rst", 32'(bus.swdio_out), 32'd0);
                    for (int k = 0; k < 8; k++) model[k] = 32'd0;
                    exp_perr = 1'b0;
                    @(negedge sck);
                    rst_n = 1'b1;
                    idle(4);
                    return;
                end
            end
            hcycle(1'b0, 1'b1, ^word);
            hcycle(1'b0, 1'b0, 1'b0);
        end else begin
            hcycle(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 32; i++) hcycle(wd[i], 1'b0, 1'b0);
            if (bad_par) exp_perr = 1'b1;
            else begin
                wr_q.push_back(wd);
                if (idx != 3'd0) model[idx] = wd;
            end
            hcycle((^wd) ^ bad_par, 1'b0, 1'b0);
        end
        idle(2);
    endtask

    initial begin
        bus.swclk   = 1'b1;
        bus.ack_cfg = 3'b001;
        for (int k = 0; k < 8; k++) model[k] = 32'd0;
        repeat (4) @(negedge sck);
        check("rst_oe", 32'(bus.swdio_oe), 32'd0);
        check("rst_out", 32'(bus.swdio_out), 32'd0);
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        check("rst_line_reset", 32'(bus.line_reset), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge sck);
        mon_en = 1'b1;
        idle(3);

        frame(8'hA9, 3'b001, 32'h5000_0000, 1'b0, -1);
        check("perr_after_good_write", 32'(bus.parity_err), 32'(exp_perr));
        frame(8'hA5, 3'b001, 32'd0, 1'b0, -1);
        frame(8'h8D, 3'b001, 32'd0, 1'b0, -1);
        frame(8'hBB, 3'b001, 32'hDEAD_BEEF, 1'b0, -1);
        frame(8'h9F, 3'b001, 32'd0, 1'b0, -1);
        frame(8'h81, 3'b001, 32'h1234_5678, 1'b0, -1);
        frame(8'hA5, 3'b001, 32'd0, 1'b0, -1);
        frame(8'hA9, 3'b010, 32'h5000_0000, 1'b0, -1);
        frame(8'hA9, 3'b100, 32'h5000_0000, 1'b0, -1);
        frame(8'hA1, 3'b001, 32'd0, 1'b0, -1);
        frame(8'hA9, 3'b001, 32'h1234_5678, 1'b1, -1);
        check("perr_after_bad_write", 32'(bus.parity_err), 32'(exp_perr));

        lr_q.push_back(1);
        for (int i = 0; i < 50; i++) hcycle(1'b1, 1'b0, 1'b0);
        idle(3);
        check("lr_pulse_seen", 32'(lr_q.size()), 32'd0);
        check("perr_after_line_reset", 32'(bus.parity_err), 32'd0);
        exp_perr = 1'b0;

        frame(8'h8D, 3'b001, 32'd0, 1'b0, -1);
        frame(8'hA5, 3'b001, 32'd0, 1'b0, 10);
        frame(8'hA5, 3'b001, 32'd0, 1'b0, -1);
        frame(8'h8D, 3'b001, 32'd0, 1'b0, -1);
        frame(8'hA9, 3'b001, 32'hCAFE_0001, 1'b0, -1);
        check("perr_final", 32'(bus.parity_err), 32'(exp_perr));

        repeat (10) @(negedge sck);
        check("wire_q_drained", 32'(wire_q.size()), 32'd0);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("lr_q_drained", 32'(lr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
